// File: rtl/eceg_decryptor_pkg.sv
// Shared definitions for the EC-ElGamal decryptor.
// Curve y^2 = x^3 + A*x + B over GF(P); affine points, (0,0) is the point at infinity.
// Holds field/point types, the FSM state encoding and the combinational point adder.
package eceg_decryptor_pkg;

  localparam int unsigned DATAWIDTH = 5;
  localparam int unsigned KEYWIDTH_DEFAULT = DATAWIDTH;

  typedef logic [DATAWIDTH-1:0] elem_t;

  localparam elem_t P = elem_t'(17);
  localparam elem_t A = elem_t'(2);

  typedef struct packed {
    elem_t x;
    elem_t y;
  } point_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDbl   = 3'd1,
    StAdd   = 3'd2,
    StFinal = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic elem_t add_mod(elem_t a, elem_t b);
    logic [DATAWIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DATAWIDTH-1:0];
  endfunction

  function automatic elem_t sub_mod(elem_t a, elem_t b);
    return add_mod(a, (b == '0) ? '0 : P - b);
  endfunction

  function automatic elem_t mul_mod(elem_t a, elem_t b);
    logic [2*DATAWIDTH-1:0] prod;
    prod = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};
    prod = prod % {{DATAWIDTH{1'b0}}, P};
    return prod[DATAWIDTH-1:0];
  endfunction

  // Fermat inverse a^(P-2); inv(0) yields 0, which is never used on a live path.
  function automatic elem_t inv_mod(elem_t a);
    elem_t e;
    elem_t r;
    e = P - elem_t'(2);
    r = elem_t'(1);
    for (int i = int'(DATAWIDTH) - 1; i >= 0; i--) begin
      r = mul_mod(r, r);
      if (e[i]) r = mul_mod(r, a);
    end
    return r;
  endfunction

  // Affine point addition with identity and inverse handling.
  function automatic point_t point_add(point_t p1, point_t p2);
    elem_t  num;
    elem_t  den;
    elem_t  lam;
    elem_t  x3;
    elem_t  y3;
    point_t r;
    num = '0;
    den = '0;
    r   = '0;
    if (p1 == '0) begin
      r = p2;
    end else if (p2 == '0) begin
      r = p1;
    end else if (p1.x == p2.x && add_mod(p1.y, p2.y) == '0) begin
      r = '0;
    end else begin
      if (p1.x == p2.x) begin
        // Same x and not inverses: doubling, y is nonzero here.
        num = add_mod(mul_mod(elem_t'(3), mul_mod(p1.x, p1.x)), A);
        den = add_mod(p1.y, p1.y);
      end else begin
        num = sub_mod(p2.y, p1.y);
        den = sub_mod(p2.x, p1.x);
      end
      lam = mul_mod(num, inv_mod(den));
      x3  = sub_mod(sub_mod(mul_mod(lam, lam), p1.x), p2.x);
      y3  = sub_mod(mul_mod(lam, sub_mod(p1.x, x3)), p1.y);
      r   = '{x: x3, y: y3};
    end
    return r;
  endfunction

endpackage

// File: rtl/eceg_decryptor_if.sv
// Request/response bundle of the EC-ElGamal decryptor.
//   start, d, c1x/c1y, c2x/c2y : request (master -> slave)
//   busy, done, mx/my          : status and decrypted point (slave -> master)
interface eceg_decryptor_if
  import eceg_decryptor_pkg::*;
#(
  parameter int unsigned KEYWIDTH = KEYWIDTH_DEFAULT
);
  logic                start;
  logic [KEYWIDTH-1:0] d;
  elem_t               c1x;
  elem_t               c1y;
  elem_t               c2x;
  elem_t               c2y;
  logic                busy;
  logic                done;
  elem_t               mx;
  elem_t               my;

  modport master (
    output start, d, c1x, c1y, c2x, c2y,
    input  busy, done, mx, my
  );

  modport slave (
    input  start, d, c1x, c1y, c2x, c2y,
    output busy, done, mx, my
  );
endinterface

// File: rtl/eceg_decryptor_scalar_mul.sv
// Constant-time MSB-first double-and-add loop computing r = d * c1.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a run (only honoured when idle); r is cleared
//   d, c1    : scalar and base point, held stable by the caller for the whole run
//   op_a/op_b: operands for the shared external point adder, sum is its result
//   r        : accumulator; final once done has been seen
//   done     : high during the last ADD cycle; r is final from the next cycle
module eceg_decryptor_scalar_mul
  import eceg_decryptor_pkg::*;
#(
  parameter int unsigned KEYWIDTH = KEYWIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEYWIDTH-1:0] d,
  input  point_t              c1,
  input  point_t              sum,
  output point_t              op_a,
  output point_t              op_b,
  output point_t              r,
  output logic                done
);
  localparam int unsigned IdxW = (KEYWIDTH > 1) ? $clog2(KEYWIDTH) : 1;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  point_t          r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      r_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            r_q     <= '0;
            idx_q   <= IdxW'(KEYWIDTH - 1);
            state_q <= StDbl;
          end
        end
        StDbl: begin
          r_q     <= sum;
          state_q <= StAdd;
        end
        StAdd: begin
          // The add is always evaluated; only the commit depends on the key bit.
          if (d[idx_q]) r_q <= sum;
          if (idx_q == '0) begin
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q - IdxW'(1);
            state_q <= StDbl;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    op_a = r_q;
    op_b = (state_q == StAdd) ? c1 : r_q;
  end

  assign r    = r_q;
  assign done = (state_q == StAdd) && (idx_q == '0);

endmodule

// File: rtl/eceg_decryptor.sv
// EC-ElGamal decryption: M = C2 - d*C1, one shared point adder, fixed 2*KEYWIDTH+2 latency.
//   clk : clock (rising edge)
//   rst : synchronous active-high reset
//   bus : slave side of eceg_decryptor_if (start/d/C1/C2 in, busy/done/M out)
module eceg_decryptor
  import eceg_decryptor_pkg::*;
#(
  parameter int unsigned KEYWIDTH = KEYWIDTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  eceg_decryptor_if.slave bus
);
  state_e              state_q;
  logic [KEYWIDTH-1:0] d_q;
  point_t              c1_q;
  point_t              c2_q;
  point_t              m_q;
  logic                busy_q;
  logic                done_q;

  logic   mul_start;
  logic   mul_done;
  point_t mul_a;
  point_t mul_b;
  point_t s;
  point_t neg_s;
  point_t add_a;
  point_t add_b;
  point_t sum;

  assign mul_start = (state_q == StIdle) && bus.start;

  eceg_decryptor_scalar_mul #(
    .KEYWIDTH(KEYWIDTH)
  ) u_scalar_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .d    (d_q),
    .c1   (c1_q),
    .sum  (sum),
    .op_a (mul_a),
    .op_b (mul_b),
    .r    (s),
    .done (mul_done)
  );

  // -O = O falls out naturally: y = 0 maps to 0.
  always_comb begin
    neg_s = '{x: s.x, y: (s.y == '0) ? '0 : P - s.y};
    if (state_q == StFinal) begin
      add_a = c2_q;
      add_b = neg_s;
    end else begin
      add_a = mul_a;
      add_b = mul_b;
    end
    sum = point_add(add_a, add_b);
  end

  // The loop sub-module toggles DBL/ADD in lockstep with this FSM; its done marks the last ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            d_q     <= bus.d;
            c1_q    <= '{x: bus.c1x, y: bus.c1y};
            c2_q    <= '{x: bus.c2x, y: bus.c2y};
            busy_q  <= 1'b1;
            state_q <= StDbl;
          end
        end
        StDbl: state_q <= StAdd;
        StAdd: state_q <= mul_done ? StFinal : StDbl;
        StFinal: begin
          m_q     <= sum;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mx   = m_q.x;
  assign bus.my   = m_q.y;

endmodule

// File: doc/eceg_decryptor.md
# eceg_decryptor

Sequential EC-ElGamal decryption engine. It accepts a ciphertext pair (C1, C2) and a private key d, and computes the plaintext point M = C2 − d·C1. The scalar product uses constant-time MSB-first double-and-add, time-multiplexing a single combinational point-adder instance. It is the receive-side counterpart of the encryption datapath (C2 = M + k·Q) and sits behind the same affine point interface, with (0,0) encoding the point at infinity.

## Interface
Parameters:
- KEYWIDTH, default `DATAWIDTH: width of private key d, in bits.
- DATAWIDTH, no parameter: taken from the `DATAWIDTH macro in parameters.vh. Curve constants `P and `A come from the same file.

Ports:
- clk  in  1  sole clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- d  in  KEYWIDTH  private key. Latched on an accepted start.
- C1x, C1y  in  DATAWIDTH  ephemeral point. Latched on an accepted start.
- C2x, C2y  in  DATAWIDTH  masked message point. Latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when Mx/My become valid.
- Mx, My  out  DATAWIDTH  decrypted point. Held until the next accepted start or rst.

## Operation
- States: IDLE, DBL, ADD, FINAL, DONE.
- IDLE:
  - On start=1, latch d, C1, C2.
  - Set accumulator R=(0,0) and bit index i=KEYWIDTH−1.
  - Go to DBL.
  - start=0 stays in IDLE.
- DBL: R ← R+R. Go to ADD.
- ADD: compute T = R+C1 every time (constant time).
  - R ← d[i] ? T : R.
  - If i==0, go to FINAL. Otherwise i ← i−1 and go to DBL.
- FINAL: compute S = R and −S = (Sx, (`P − Sy) mod `P), with −O = O.
  - M ← C2 + (−S). Register M into Mx/My. Go to DONE.
- DONE: done=1, busy=0. Go to IDLE. Mx/My stay valid.
- One point adder is shared. Its operand mux is selected by state:
  - DBL: (R, R).
  - ADD: (R, C1).
  - FINAL: (C2, −S).
- The point adder's identity and inverse handling is relied on. No special-casing of O is done in this block except the −O rule above.
- Arithmetic is mod `P on DATAWIDTH-bit values. Inputs are assumed already reduced (< `P); out-of-range inputs give an undefined M but a correct cycle count.
- Bit counter width is clog2(KEYWIDTH). The transition on i==0 must not rely on wrap-around.
- Boundary cases:
  - d=0 ⇒ M=C2.
  - C1=O ⇒ M=C2.
  - C2=d·C1 ⇒ M=(0,0).
  - start while busy: ignored, and the latched operands are unchanged.
  - rst in any state: IDLE next cycle, all registers cleared.

## Timing
- Reset values: busy=0, done=0, Mx=0, My=0, state=IDLE.
- Cycle 0 is the edge that samples start=1 in IDLE. busy is 1 in cycles 1..2·KEYWIDTH+1.
- done=1 in exactly cycle 2·KEYWIDTH+2, with Mx/My valid in the same cycle.
- Latency from start to done is fixed at 2·KEYWIDTH+2 cycles, independent of d and the operands.
- A new start is accepted in the cycle after DONE, i.e. in IDLE. Back-to-back throughput is one result per 2·KEYWIDTH+3 cycles.
- A start pulse arriving in the DONE cycle is ignored.
- The critical path is one point addition, including ModDiv, per cycle. The target clock is set accordingly; no internal pipelining is allowed.

## Structure
- parameters.vh (shared):
  - Existing: `DATAWIDTH, `P, `A.
  - Added: `KEYWIDTH default.
  - Added: the state encoding as `defines (IDLE=0, DBL=1, ADD=2, FINAL=3, DONE=4, 3 bits).
- Natural sub-module: ec_scalar_mul.
  - Contains the DBL/ADD loop, the bit counter and the adder mux.
  - Has a start/done handshake.
  - The top level adds latching, negation, the final addition and the output registers.
- Reuses the existing point-adder and point-inversion modules unchanged.

## Test plan
- Round-trip: pick M, private key d=7, k=5, generator G. Drive C1=5·G and C2=M+5·(7·G), both from a golden model. Required: done in cycle 2·KEYWIDTH+2 with (Mx,My)=M.
- d=0, C1=G, C2=(5,1) on a valid curve point. Required: M=(5,1), busy high for exactly 2·KEYWIDTH+1 cycles.
- d=1, C1=C2=G. Required: M=(0,0). Also C1=(0,0) with arbitrary d. Required: M=C2.
- Pulse start again at cycle 3 of a run with different operands. Required: ignored, with result and latency matching the first request only.
- Assert rst at cycle KEYWIDTH. Required: next cycle busy=0, done=0, Mx=My=0. A fresh start then completes normally.
- Random regression: 500 random (d, M, k) triples against the golden model. Check M and constant latency.
